// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch unit and its branch target buffer.
// Holds the reset PC default, BTB geometry and the 2-bit direction counter type.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int unsigned BTB_ENTRIES_DEFAULT = 16;
  localparam int unsigned BTB_IDX_W           = $clog2(BTB_ENTRIES_DEFAULT);
  localparam int unsigned BTB_TAG_W           = 30 - BTB_IDX_W;
  localparam int unsigned BTB_TGT_W           = 30;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // Saturating step of the direction counter toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    unique case (cur)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// single update port written on the clock edge (reads see pre-update state).
module branch_target_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [29:0]          lookup_pc,
  output logic                 lookup_taken,
  output logic [BTB_TGT_W-1:0] lookup_target,
  input  logic                 update_en,
  input  logic [29:0]          update_pc,
  input  logic [BTB_TGT_W-1:0] update_target,
  input  logic                 update_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [BTB_TGT_W-1:0] target_q [ENTRIES];
  ctr_t                 ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_write;

  always_comb begin
    lk_idx        = lookup_pc[IDX_W-1:0];
    lk_tag        = lookup_pc[29:IDX_W];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lookup_taken  = lk_hit && ctr_q[lk_idx][1];
    lookup_target = target_q[lk_idx];
  end

  always_comb begin
    up_idx   = update_pc[IDX_W-1:0];
    up_tag   = update_pc[29:IDX_W];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    // A not-taken miss leaves the entry alone; every other update writes it.
    up_write = update_en && (up_hit || update_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (up_write) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observable through a set valid bit.
  always_ff @(posedge clk) begin
    if (up_write) begin
      tag_q[up_idx] <= up_tag;
      if (update_taken) begin
        target_q[up_idx] <= update_target;
      end
      ctr_q[up_idx] <= up_hit ? ctr_next(ctr_q[up_idx], update_taken) : WEAK_T;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch PC generation: PC register, fetch-valid flag and next-PC
// selection between redirect, stall, BTB prediction and sequential fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_En,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  input  logic        Update_En,
  input  logic [31:0] Update_PC,
  input  logic [31:0] Update_Target,
  input  logic        Update_Taken,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic        Predict_Taken_F,
  output logic        Valid_F
);

  logic [29:0]          pc_q;
  logic [29:0]          pc_next;
  logic                 valid_q;
  logic                 btb_taken;
  logic [BTB_TGT_W-1:0] btb_target;
  logic                 unused_low_bits;

  assign unused_low_bits = ^{Redirect_PC[1:0], Update_PC[1:0], Update_Target[1:0]};

  branch_target_buffer #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (CLK),
    .rst_n         (RST),
    .lookup_pc     (pc_q),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .update_en     (Update_En),
    .update_pc     (Update_PC[31:2]),
    .update_target (Update_Target[31:2]),
    .update_taken  (Update_Taken)
  );

  assign PC_F            = {pc_q, 2'b00};
  assign PC_Plus_4_F     = PC_F + 32'd4;
  assign Valid_F         = valid_q;
  assign Predict_Taken_F = btb_taken && valid_q;

  // The reset PC is held until the first edge that marks it a real fetch.
  always_comb begin
    pc_next = PC_Plus_4_F[31:2];
    if (Redirect_En) begin
      pc_next = Redirect_PC[31:2];
    end else if (Stall_En || !valid_q) begin
      pc_next = pc_q;
    end else if (Predict_Taken_F) begin
      pc_next = btb_target;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q    <= RESET_PC[31:2];
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, stall, redirect,
// BTB training and saturation, aliasing, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        upd;
  logic [31:0] upd_pc;
  logic [31:0] upd_tgt;
  logic        upd_taken;
  logic [31:0] pc_f;
  logic [31:0] pc4;
  logic        pred;
  logic        valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .CLK             (clk),
    .RST             (rst_n),
    .Stall_En        (stall),
    .Redirect_En     (redir),
    .Redirect_PC     (redir_pc),
    .Update_En       (upd),
    .Update_PC       (upd_pc),
    .Update_Target   (upd_tgt),
    .Update_Taken    (upd_taken),
    .PC_F            (pc_f),
    .PC_Plus_4_F     (pc4),
    .Predict_Taken_F (pred),
    .Valid_F         (valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; redir = 1'b0; upd = 1'b0;
    redir_pc = '0; upd_pc = '0; upd_tgt = '0; upd_taken = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    redir = 1'b1; redir_pc = addr;
    step();
    redir = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    upd = 1'b1; upd_pc = pc; upd_tgt = tgt; upd_taken = taken;
    step();
    upd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) step();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc_f, 32'h0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL rst_pred: got %b expected 0", pred); end
    rst_n = 1'b1;
    #1;
    checks++; if (pc_f !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL rel_pc_valid: got %h/%b expected 00000000/0", pc_f, valid); end
    step();
    checks++; if (pc_f !== 32'h0 || valid !== 1'b1) begin errors++; $display("FAIL first_fetch: got %h/%b expected 00000000/1", pc_f, valid); end
    step();
    checks++; if (pc_f !== 32'h4 || valid !== 1'b1) begin errors++; $display("FAIL seq_4: got %h/%b expected 00000004/1", pc_f, valid); end
    step();
    checks++; if (pc_f !== 32'h8 || pc4 !== 32'hC) begin errors++; $display("FAIL seq_8: got %h/%h expected 00000008/0000000c", pc_f, pc4); end
  endtask

  task automatic test_stall();
    repeat (2) step();
    checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL pre_stall: got %h expected %h", pc_f, 32'h10); end
    stall = 1'b1;
    step();
    checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL stall_1: got %h expected %h", pc_f, 32'h10); end
    step();
    checks++; if (pc_f !== 32'h10 || valid !== 1'b1) begin errors++; $display("FAIL stall_2: got %h/%b expected 00000010/1", pc_f, valid); end
    stall = 1'b0;
    step();
    checks++; if (pc_f !== 32'h14) begin errors++; $display("FAIL post_stall: got %h expected %h", pc_f, 32'h14); end
  endtask

  task automatic test_redirect_during_stall();
    stall = 1'b1;
    redirect_to(32'h0000_0203);
    stall = 1'b0;
    checks++; if (pc_f !== 32'h200 || valid !== 1'b1) begin errors++; $display("FAIL redir_stall: got %h/%b expected 00000200/1", pc_f, valid); end
  endtask

  task automatic test_training();
    train(32'h40, 32'h100, 1'b1);
    redirect_to(32'h40);
    checks++; if (pc_f !== 32'h40 || pred !== 1'b1) begin errors++; $display("FAIL train_hit: got %h/%b expected 00000040/1", pc_f, pred); end
    step();
    checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL train_target: got %h expected %h", pc_f, 32'h100); end
    // Update the entry being looked up: the edge must use the old prediction.
    redirect_to(32'h40);
    train(32'h40, 32'h300, 1'b0);
    checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL read_before_write: got %h expected %h", pc_f, 32'h100); end
    train(32'h40, 32'h300, 1'b0);
    redirect_to(32'h40);
    checks++; if (pc_f !== 32'h40 || pred !== 1'b0) begin errors++; $display("FAIL untrain_pred: got %h/%b expected 00000040/0", pc_f, pred); end
    step();
    checks++; if (pc_f !== 32'h44) begin errors++; $display("FAIL untrain_next: got %h expected %h", pc_f, 32'h44); end
    train(32'h40, 32'h300, 1'b0);
    train(32'h40, 32'h180, 1'b1);
    train(32'h40, 32'h180, 1'b1);
    redirect_to(32'h40);
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL sat_low: got %b expected 1", pred); end
    step();
    checks++; if (pc_f !== 32'h180) begin errors++; $display("FAIL target_rewrite: got %h expected %h", pc_f, 32'h180); end
    train(32'h40, 32'h180, 1'b1);
    train(32'h40, 32'h180, 1'b1);
    train(32'h40, 32'h300, 1'b0);
    redirect_to(32'h40);
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL sat_high_weak: got %b expected 1", pred); end
    step();
    checks++; if (pc_f !== 32'h180) begin errors++; $display("FAIL target_kept_nt: got %h expected %h", pc_f, 32'h180); end
    train(32'h40, 32'h300, 1'b0);
    redirect_to(32'h40);
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL sat_high_drop: got %b expected 0", pred); end
  endtask

  task automatic test_aliasing_and_wrap();
    train(32'h40, 32'h100, 1'b1);
    train(32'h440, 32'h500, 1'b0);
    redirect_to(32'h440);
    checks++; if (pc_f !== 32'h440 || pred !== 1'b0) begin errors++; $display("FAIL alias_pred: got %h/%b expected 00000440/0", pc_f, pred); end
    step();
    checks++; if (pc_f !== 32'h444) begin errors++; $display("FAIL alias_next: got %h expected %h", pc_f, 32'h444); end
    redirect_to(32'h40);
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL miss_nt_kept: got %b expected 1", pred); end
    step();
    checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL miss_nt_target: got %h expected %h", pc_f, 32'h100); end
    train(32'h440, 32'h500, 1'b1);
    redirect_to(32'h440);
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL replace_pred: got %b expected 1", pred); end
    step();
    checks++; if (pc_f !== 32'h500) begin errors++; $display("FAIL replace_target: got %h expected %h", pc_f, 32'h500); end
    redirect_to(32'h40);
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL replaced_old: got %b expected 0", pred); end
    redirect_to(32'hFFFF_FFFC);
    checks++; if (pc_f !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h/%h expected fffffffc/00000000", pc_f, pc4); end
    step();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected %h", pc_f, 32'h0); end
  endtask

  task automatic test_async_reset();
    train(32'h80, 32'h900, 1'b1);
    step();
    redir = 1'b1; redir_pc = 32'h0000_0700;
    upd = 1'b1; upd_pc = 32'h40; upd_tgt = 32'h100; upd_taken = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc_f !== 32'h0 || valid !== 1'b0 || pred !== 1'b0) begin errors++; $display("FAIL async_rst: got %h/%b/%b expected 00000000/0/0", pc_f, valid, pred); end
    step();
    idle();
    rst_n = 1'b1;
    step();
    checks++; if (pc_f !== 32'h0 || valid !== 1'b1) begin errors++; $display("FAIL post_rst_fetch: got %h/%b expected 00000000/1", pc_f, valid); end
    step();
    checks++; if (pc_f !== 32'h4) begin errors++; $display("FAIL post_rst_seq: got %h expected %h", pc_f, 32'h4); end
    redirect_to(32'h40);
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL btb_cleared_40: got %b expected 0", pred); end
    redirect_to(32'h80);
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL btb_cleared_80: got %b expected 0", pred); end
    step();
    checks++; if (pc_f !== 32'h84) begin errors++; $display("FAIL btb_cleared_next: got %h expected %h", pc_f, 32'h84); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect_during_stall();
    test_training();
    test_aliasing_and_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: BTB_ENTRIES, default 16, number of direct-mapped branch target buffer (BTB) entries; power of two.
REQ-003 Port: CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: RST  in  1  reset; asynchronous, active-low.
REQ-005 Port: Stall_En  in  1  hold the current PC (decode or later stage stalled).
REQ-006 Port: Redirect_En  in  1  execute-stage mispredict or jump; overrides everything except reset.
REQ-007 Port: Redirect_PC  in  32  corrected fetch address.
REQ-008 Port: Update_En  in  1  resolved branch or jump this cycle; write the BTB.
REQ-009 Port: Update_PC  in  32  PC of the resolved branch.
REQ-010 Port: Update_Target  in  32  resolved taken target.
REQ-011 Port: Update_Taken  in  1  resolved direction.
REQ-012 Port: PC_F  out  32  current fetch address.
REQ-013 Port: PC_Plus_4_F  out  32  PC_F + 4.
REQ-014 Port: Predict_Taken_F  out  1  BTB predicts taken for PC_F.
REQ-015 Port: Valid_F  out  1  PC_F holds a real fetch; low after reset.

Function
REQ-016 PC_F SHALL be registered; bits [1:0] are always 2'b00, and Redirect_PC[1:0] and Update_Target[1:0] are ignored.
REQ-017 Next-PC priority SHALL be, highest first:
  - Redirect_En -> Redirect_PC
  - Stall_En -> hold PC_F
  - Predict_Taken_F -> BTB target
  - otherwise -> PC_Plus_4_F
REQ-018 PC_Plus_4_F SHALL be combinational, modulo 2^32; 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-019 Valid_F SHALL be registered: 0 in reset, 1 from the first rising edge with RST high, and held 1 thereafter, including across stall and redirect.
REQ-020 BTB lookup SHALL be combinational on PC_F:
  - index = PC_F[5:2] (log2 BTB_ENTRIES bits)
  - tag = PC_F[31:6]
  - hit = valid and tag match
  - Predict_Taken_F = hit and counter[1] and Valid_F
REQ-021 Each BTB entry SHALL hold: valid bit, tag, 30-bit target, and a 2-bit saturating counter (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11).
REQ-022 On Update_En with a tag hit at Update_PC's index:
  - counter increments if Update_Taken, else decrements; saturates at 00 and 11
  - target is rewritten only when Update_Taken
REQ-023 On Update_En with a miss and Update_Taken=1, the entry SHALL be replaced: valid=1, new tag, new target, counter=WEAK_T.
REQ-024 On Update_En with a miss and Update_Taken=0, the BTB SHALL be unchanged.
REQ-025 A same-cycle lookup and update of one index SHALL see the pre-update contents; the write takes effect on the edge (read-before-write).
REQ-026 Update_En SHALL be honoured regardless of Stall_En or Redirect_En.
REQ-027 One-cycle latency: a change in PC_F and the BTB state resulting from an update are both visible the cycle after the edge.

Reset
REQ-028 While RST=0, with no clock required:
  - PC_F = RESET_PC
  - Valid_F = 0 (so Predict_Taken_F = 0)
  - all BTB valid bits = 0
REQ-029 BTB tags, targets and counters SHALL need no reset; they are unobservable while valid=0.
REQ-030 Reset asserted mid-operation SHALL abort any pending redirect or update; the first post-reset fetch is RESET_PC.

Structure
REQ-031 A shared package SHALL hold: the RESET_PC default, BTB index/tag width constants, and a 2-bit counter enum typedef.
REQ-032 BTB storage, lookup and update SHALL sit in one sub-module, branch_target_buffer; fetch_unit keeps the PC register, Valid_F and next-PC mux.

Verification
REQ-033 Reset release: RST low 3 cycles then high -> PC_F=0x0 with Valid_F=0, then sequence 0x0, 0x4, 0x8 with Valid_F=1.
REQ-034 Stall: Stall_En=1 for 2 cycles at PC_F=0x10 -> PC_F holds 0x10 for 2 cycles, then 0x14.
REQ-035 Redirect during stall: Stall_En=1, Redirect_En=1, Redirect_PC=0x203 -> next PC_F=0x200.
REQ-036 Training:
  - Update_PC=0x40, Taken=1, Target=0x100 -> at PC_F=0x40, Predict_Taken_F=1 and next PC_F=0x100
  - then two not-taken updates -> Predict_Taken_F=0 and next PC_F=0x44
REQ-037 Aliasing and wrap:
  - entry trained at 0x40; fetch at 0x440 -> no prediction
  - Redirect_PC=0xFFFF_FFFC -> PC_Plus_4_F=0x0, next PC_F=0x0
REQ-038 Asynchronous reset mid-run: RST dropped between edges -> PC_F=RESET_PC and Valid_F=0 immediately; BTB empty after release (0x40 no longer predicts).
